// File: rtl/contador_secuencia.sv
`default_nettype none
// ============================================================================
//  Module      : contador_secuencia
//  Description : Arbitrary-sequence counter. A writable table of DEPTH
//                entries is stepped through by an index register moving
//                forward or backward on the falling clock edge, with load,
//                programmable length, terminal count and sticky error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_secuencia #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             C,
  input  logic             nR,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic [AW-1:0]    LI,
  input  logic [AW-1:0]    LEN,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] Q,
  output logic [AW-1:0]    IDX,
  output logic             TC,
  output logic             ERR
);

  // One extra bit so DEPTH == 2**AW is representable in the address check.
  localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_one   = AW'(1);

  logic [AW-1:0]    r_idx;
  logic             r_err;
  logic [WIDTH-1:0] r_table [DEPTH];

  logic [AW-1:0]    w_nextIdx;
  logic             w_idxErr;
  logic             w_wrErr;
  logic             w_idxInRange;
  logic             w_atLast;
  logic             w_atFirst;
  logic             w_liInRange;
  logic             w_waValid;
  logic [WIDTH-1:0] w_q;

  assign w_idxInRange = (r_idx <= LEN);
  assign w_atLast     = (r_idx == LEN);
  assign w_atFirst    = (r_idx == '0);
  assign w_liInRange  = (LI <= LEN);
  assign w_waValid    = ({1'b0, WA} < c_depth);
  assign w_wrErr      = WE & ~w_waValid;

  // Next index: load beats count; an index stranded above LEN is recovered.
  // Increment only happens when r_idx < LEN, so it never overflows AW bits.
  always_comb begin
    w_nextIdx = r_idx;
    w_idxErr  = 1'b0;
    if (LD) begin
      if (w_liInRange) begin
        w_nextIdx = LI;
      end else begin
        w_nextIdx = '0;
        w_idxErr  = 1'b1;
      end
    end else if (EN) begin
      if (!w_idxInRange) begin
        w_nextIdx = UP ? '0 : LEN;
        w_idxErr  = 1'b1;
      end else if (UP) begin
        w_nextIdx = w_atLast ? '0 : (r_idx + c_one);
      end else begin
        w_nextIdx = w_atFirst ? LEN : (r_idx - c_one);
      end
    end
  end

  // Index and sticky error register, falling edge, async active-low clear.
  always_ff @(negedge C or negedge nR) begin
    if (!nR) begin
      r_idx <= '0;
      r_err <= 1'b0;
    end else begin
      r_idx <= w_nextIdx;
      if (w_idxErr || w_wrErr) begin
        r_err <= 1'b1;
      end
    end
  end

  // Table storage; each entry resets to its own index (identity sequence).
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_table
      localparam logic [WIDTH-1:0] c_init = WIDTH'(i);
      localparam logic [AW-1:0]    c_addr = AW'(i);
      // Entry i captures write data when addressed.
      always_ff @(negedge C or negedge nR) begin
        if (!nR) begin
          r_table[i] <= c_init;
        end else if (WE && (WA == c_addr)) begin
          r_table[i] <= WD;
        end
      end
    end
  endgenerate

  // Combinational table read at the current index.
  always_comb begin
    w_q = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_idx == AW'(i)) begin
        w_q = r_table[i];
      end
    end
  end

  assign Q   = w_q;
  assign IDX = r_idx;
  assign ERR = r_err;
  assign TC  = EN & w_idxInRange & ((UP & w_atLast) | (~UP & w_atFirst));

endmodule
`default_nettype wire

// File: tb/tb_contador_secuencia.sv
`default_nettype none
// ============================================================================
//  Module      : tb_contador_secuencia
//  Description : Self-checking bench for contador_secuencia against a
//                behavioural model of the sequence table and index.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_secuencia;

  localparam int WIDTH = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 5;

  logic             C;
  logic             nR;
  logic             EN;
  logic             UP;
  logic             LD;
  logic [AW-1:0]    LI;
  logic [AW-1:0]    LEN;
  logic             WE;
  logic [AW-1:0]    WA;
  logic [WIDTH-1:0] WD;
  logic [WIDTH-1:0] Q;
  logic [AW-1:0]    IDX;
  logic             TC;
  logic             ERR;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int mIdx;
  int mErr;
  int mTbl [DEPTH];

  contador_secuencia #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .C(C), .nR(nR), .EN(EN), .UP(UP), .LD(LD), .LI(LI), .LEN(LEN),
    .WE(WE), .WA(WA), .WD(WD), .Q(Q), .IDX(IDX), .TC(TC), .ERR(ERR)
  );

  // Clock: falling edges at 5, 15, 25 ...
  initial C = 1'b1;
  always #5 C = ~C;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mIdx = 0;
    mErr = 0;
    for (int i = 0; i < DEPTH; i++) mTbl[i] = i % (1 << WIDTH);
  endtask

  // One clock cycle: drive inputs, check TC, take the falling edge,
  // advance the model, check outputs. Entered and left at posedge+1.
  task automatic cyc(input logic en, input logic up, input logic ld, input int li,
                     input int len, input logic we, input int wa, input int wd);
    int expTc;
    EN = en; UP = up; LD = ld; LI = AW'(li); LEN = AW'(len);
    WE = we; WA = AW'(wa); WD = WIDTH'(wd);
    #1;
    expTc = (en && mIdx <= len && ((up && mIdx == len) || (!up && mIdx == 0))) ? 1 : 0;
    chk("tc", int'(TC), expTc);
    @(negedge C);
    if (ld) begin
      if (li <= len) mIdx = li;
      else begin mIdx = 0; mErr = 1; end
    end else if (en) begin
      if (mIdx > len) begin
        mIdx = up ? 0 : len;
        mErr = 1;
      end else if (up) mIdx = (mIdx + 1) % (len + 1);
      else             mIdx = (mIdx + len) % (len + 1);
    end
    if (we) begin
      if (wa < DEPTH) mTbl[wa] = wd;
      else            mErr = 1;
    end
    #1;
    chk("idx", int'(IDX), mIdx);
    chk("q",   int'(Q),   mTbl[mIdx]);
    chk("err", int'(ERR), mErr);
    @(posedge C);
    #1;
  endtask

  initial begin
    int seqUp [6];
    int seqDn [3];
    seqUp = '{2, 4, 6, 7, 10, 1};
    seqDn = '{10, 7, 6};

    nR = 1'b0; EN = 1'b1; UP = 1'b0; LD = 1'b0; LI = '0; LEN = AW'(15);
    WE = 1'b0; WA = '0; WD = '0;
    modelReset();
    @(posedge C); #1;
    chk("rst_q",   int'(Q),   0);
    chk("rst_idx", int'(IDX), 0);
    chk("rst_err", int'(ERR), 0);
    chk("rst_tc",  int'(TC),  1);
    nR = 1'b1;

    // Plain count through the identity table, wrapping at 15
    for (int k = 0; k < 16; k++) begin
      cyc(1, 1, 0, 0, 15, 0, 0, 0);
      chk("cnt_q", int'(Q), (k + 1) % 16);
    end

    // Program {1,2,4,6,7,10} with counting disabled
    cyc(0, 1, 0, 0, 5, 1, 0, 1);
    cyc(0, 1, 0, 0, 5, 1, 1, 2);
    cyc(0, 1, 0, 0, 5, 1, 2, 4);
    cyc(0, 1, 0, 0, 5, 1, 3, 6);
    cyc(0, 1, 0, 0, 5, 1, 4, 7);
    cyc(0, 1, 0, 0, 5, 1, 5, 10);
    chk("prog_q0", int'(Q), 1);
    for (int k = 0; k < 6; k++) begin
      cyc(1, 1, 0, 0, 5, 0, 0, 0);
      chk("prog_up", int'(Q), seqUp[k]);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0, 5, 0, 0, 0);
      chk("prog_dn", int'(Q), seqDn[k]);
    end

    // Loads in and out of range
    cyc(0, 1, 1, 3, 5, 0, 0, 0);
    chk("ld_q", int'(Q), 6);
    chk("ld_err", int'(ERR), 0);
    cyc(1, 1, 1, 9, 5, 0, 0, 0);
    chk("ldbad_idx", int'(IDX), 0);
    chk("ldbad_q", int'(Q), 1);
    chk("ldbad_err", int'(ERR), 1);

    // LEN shrinking under a running count
    cyc(0, 1, 1, 5, 5, 0, 0, 0);
    cyc(1, 1, 0, 0, 2, 0, 0, 0);
    chk("shrink_up", int'(IDX), 0);
    cyc(0, 0, 1, 5, 5, 0, 0, 0);
    cyc(1, 0, 0, 0, 2, 0, 0, 0);
    chk("shrink_dn", int'(IDX), 2);

    // Write to the entry that the count moves onto
    cyc(1, 1, 0, 0, 5, 1, 3, 15);
    chk("wrmove_q", int'(Q), 15);

    // Asynchronous reset between edges at index 4
    cyc(0, 1, 1, 4, 5, 0, 0, 0);
    EN = 1'b0; LD = 1'b0;
    nR = 1'b0;
    #1;
    modelReset();
    chk("arst_idx", int'(IDX), 0);
    chk("arst_q",   int'(Q),   0);
    chk("arst_err", int'(ERR), 0);
    #1;
    nR = 1'b1;
    @(posedge C); #1;

    // Out-of-range write: dropped, ERR set
    cyc(0, 1, 0, 0, 15, 1, DEPTH, 9);
    chk("wrbad_err", int'(ERR), 1);
    for (int k = 0; k < 16; k++) begin
      cyc(1, 1, 0, 0, 15, 0, 0, 0);
    end

    // Randomised traffic, including occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        nR = 1'b0;
        #1;
        modelReset();
        chk("rnd_rst_idx", int'(IDX), 0);
        nR = 1'b1;
      end
      cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 9) == 0), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 15)), logic'($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 18)), int'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/contador_secuencia.md
# contador_secuencia

Parametrised arbitrary-sequence counter: a programmable table of DEPTH entries, each WIDTH bits wide, is stepped through by an index register that moves forward or backward on the falling edge of the clock. The next generation of the team's hard-wired arbitrary counters. Any sequence (repeats allowed) is loaded at run time instead of being fixed by gate equations, and the block adds programmable length, direction, load, terminal count and invalid-index recovery. It sits between the clock source and display/decoder logic, replacing a fixed counter plus recoding stage.

## Interface
- WIDTH, 4, bits per sequence value
- DEPTH, 16, table entries (2..2^AW)
- AW, 4, index width; DEPTH <= 2^AW
- C  in  1  clock; all state changes on the falling edge
- nR  in  1  reset, asynchronous, active-low
- EN  in  1  count enable
- UP  in  1  direction: 1 forward, 0 backward
- LD  in  1  load index (priority over EN)
- LI  in  AW  index to load
- LEN  in  AW  last valid index (sequence length minus 1), must be < DEPTH
- WE  in  1  table write enable
- WA  in  AW  table write address
- WD  in  WIDTH  table write data
- Q  out  WIDTH  current sequence value = table[IDX] (combinational read)
- IDX  out  AW  current index
- TC  out  1  terminal count (combinational)
- ERR  out  1  sticky error flag

## Operation
- Reset (nR low, asynchronous): IDX=0, ERR=0, table[i]=i mod 2^WIDTH (identity), so Q=0 and TC=EN&~UP. All inputs are ignored while nR is low.
- Index update per falling edge, in priority order:
  - LD=1, LI<=LEN: IDX<=LI.
  - LD=1, LI>LEN: IDX<=0, ERR<=1.
  - EN=1, IDX>LEN (LEN reduced under a running count): IDX<=0 if UP, else IDX<=LEN; ERR<=1.
  - EN=1, UP=1: IDX<=0 if IDX==LEN, else IDX+1.
  - EN=1, UP=0: IDX<=LEN if IDX==0, else IDX-1.
  - Otherwise IDX holds.
- Table write: on a falling edge with WE=1 and WA<DEPTH, table[WA]<=WD. A write with WA>=DEPTH is dropped and sets ERR.
- Simultaneous write and index move: both happen on the same edge. After the edge, Q shows table[new IDX] with the new contents.
- LEN=0: the counter stays at index 0 and TC=EN whenever IDX=0.
- TC = EN & IDX<=LEN & ((UP & IDX==LEN) | (~UP & IDX==0)). It marks the step that wraps.
- ERR is cleared only by reset.
- Index arithmetic is modulo LEN+1. No intermediate value wider than AW is produced.

## Timing
- Single clock domain; all registers update on the falling edge of C.
- Load-to-output latency: 1 falling edge. Q, IDX and TC are valid after that edge plus combinational delay.
- A write to the entry under IDX is visible on Q right after the writing edge.
- Changes on LEN and UP affect TC combinationally within the same cycle.
- nR deasserting between edges: the first state change occurs on the next falling edge. nR asserting mid-cycle clears state immediately.
- No handshake; the caller must hold EN/LD/WE stable around the falling edge.

## Test plan
- Reset then count: nR pulse, EN=1, UP=1, LEN=15 -> Q=0,1,...,15,0. TC high only while IDX=15.
- Programmed sequence: write table[0..5]={1,2,4,6,7,10}, LEN=5, UP=1 -> Q=1,2,4,6,7,10,1. Then UP=0 from IDX=0 -> Q=10,7,6.
- Load: LD=1, LI=3 with LEN=5 -> IDX=3, Q=6, ERR=0. LD=1, LI=9 -> IDX=0, Q=1, ERR=1 until next reset.
- LEN shrink: IDX=5 running, set LEN=2 -> next edge IDX=0 (UP=1), ERR=1. With UP=0 the same condition gives IDX=2.
- Write under count: WE=1, WA=IDX+1, WD=15, EN=1, UP=1 -> after the edge Q=15. A write with WA=DEPTH sets ERR and leaves the table unchanged.
- Async reset mid-sequence: nR low between edges at IDX=4 -> IDX=0, Q=0, table back to identity immediately, with no clock edge needed.
